// File: rtl/display_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_scanner_pkg
// Brief    : Shared types, widths and blanking helper for the 7-segment scanner.
// Revision : 1.0
// ============================================================================
package display_scanner_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        GUARD = 1'b1
    } scan_state_t;

    // Callers zero-extend their value to MAX_DIGITS nibbles; the unused upper
    // nibbles are zero, so the leading-zero scan yields the same mask.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [MAX_DIGITS*NIBBLE_W-1:0] value,
        input logic                           lz
    );
        logic all_zero;
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (value[i*NIBBLE_W +: NIBBLE_W] == '0);
            lz_mask[i] = lz && all_zero;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scanner_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_timer
// Brief    : Show-interval prescaler and guard-interval counter for the scanner.
// Revision : 1.0
// ============================================================================
module scan_timer #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_GUARD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_show,
    output logic o_show_end,
    output logic o_guard_end
);

    localparam int c_PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_GW = (BLANK_GUARD > 1) ? $clog2(BLANK_GUARD) : 1;
    localparam logic [c_PW-1:0] c_P_END = c_PW'(REFRESH_DIV - 1);
    localparam logic [c_GW-1:0] c_G_END = c_GW'(BLANK_GUARD - 1);

    logic [c_PW-1:0] r_pcnt;
    logic [c_GW-1:0] r_gcnt;

    assign o_show_end  = i_show && (r_pcnt == c_P_END);
    assign o_guard_end = !i_show && (r_gcnt == c_G_END);

    // Each counter idles at zero outside its own phase and restarts at its terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_gcnt <= '0;
        end else begin
            if (i_show && !o_show_end) begin
                r_pcnt <= r_pcnt + 1'b1;
            end else begin
                r_pcnt <= '0;
            end
            if (!i_show && !o_guard_end) begin
                r_gcnt <= r_gcnt + 1'b1;
            end else begin
                r_gcnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : display_scanner
// Brief    : Tear-free multiplexed hex scanner for a common-anode 7-segment bank.
// Revision : 1.0
// ============================================================================
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_GUARD = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic                          load,
    input  logic                          lz_suppress,
    output logic [3:0]                    nibble,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done,
    output logic                          pending
);

    localparam int c_IW = $clog2(NUM_DIGITS);
    localparam int c_VW = NIBBLE_W * NUM_DIGITS;
    localparam int c_XW = $clog2(MAX_DIGITS);
    localparam int c_EW = MAX_DIGITS * NIBBLE_W;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NUM_DIGITS - 1);

    scan_state_t           r_state, w_state_nx;
    logic [c_VW-1:0]       r_active, w_active_nx, r_pend_val;
    logic                  r_active_lz, w_active_lz_nx, r_pend_lz;
    logic                  r_pending, w_pending_nx;
    logic [c_IW-1:0]       r_idx, w_idx_nx;
    logic [NUM_DIGITS-1:0] r_anode_n, w_anode_nx;
    logic [NIBBLE_W-1:0]   r_nibble, w_nibble_nx;
    logic                  r_frame_done, w_frame_nx;
    logic                  w_wrap;
    logic                  w_show_end, w_guard_end;
    logic [MAX_DIGITS-1:0] w_blank;

    scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_GUARD (BLANK_GUARD)
    ) u_scan_timer (
        .clk         (clk),
        .rst         (rst),
        .i_show      (r_state == SHOW),
        .o_show_end  (w_show_end),
        .o_guard_end (w_guard_end)
    );

    assign w_blank = lz_mask(c_EW'(r_active), r_active_lz);

    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_anode_nx     = r_anode_n;
        w_frame_nx     = 1'b0;
        w_wrap         = 1'b0;
        w_active_nx    = r_active;
        w_active_lz_nx = r_active_lz;
        w_nibble_nx    = '0;

        case (r_state)
            GUARD: begin
                if (w_guard_end) begin
                    w_state_nx = SHOW;
                    w_anode_nx = '1;
                    if (!w_blank[c_XW'(r_idx)]) begin
                        w_anode_nx[r_idx] = 1'b0;
                    end
                end
            end
            SHOW: begin
                if (w_show_end) begin
                    w_state_nx = GUARD;
                    w_anode_nx = '1;
                    if (r_idx == c_LAST) begin
                        w_idx_nx   = '0;
                        w_wrap     = 1'b1;
                        w_frame_nx = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = GUARD;
                w_anode_nx = '1;
            end
        endcase

        // Transfer uses the pending contents as they stood before this edge's load.
        if (w_wrap && r_pending) begin
            w_active_nx    = r_pend_val;
            w_active_lz_nx = r_pend_lz;
        end
        w_pending_nx = load ? 1'b1 : (w_wrap ? 1'b0 : r_pending);

        // Nibble leads the anode so the decoder has settled before the digit lights.
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (w_idx_nx == c_IW'(d)) begin
                w_nibble_nx = w_active_nx[d*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= GUARD;
            r_idx        <= '0;
            r_anode_n    <= '1;
            r_nibble     <= '0;
            r_frame_done <= 1'b0;
            r_active     <= '0;
            r_active_lz  <= 1'b0;
            r_pend_val   <= '0;
            r_pend_lz    <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_anode_n    <= w_anode_nx;
            r_nibble     <= w_nibble_nx;
            r_frame_done <= w_frame_nx;
            r_active     <= w_active_nx;
            r_active_lz  <= w_active_lz_nx;
            r_pending    <= w_pending_nx;
            if (load) begin
                r_pend_val <= value;
                r_pend_lz  <= lz_suppress;
            end
        end
    end

    assign nibble     = r_nibble;
    assign anode_n    = r_anode_n;
    assign digit_idx  = r_idx;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule
`default_nettype wire

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexes a NUM_DIGITS-digit hex value onto a common-anode 7-segment bank.
- Sits directly upstream of the hex-to-segment decoder. It drives the decoder's 4-bit nibble input and the active-low digit anode enables.
- Provides tear-free value updates, anti-ghosting guard intervals and optional leading-zero suppression.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant.
- REFRESH_DIV, 50000, clk cycles each digit is lit (>=1).
- BLANK_GUARD, 2, clk cycles with all anodes off between digits (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  4*NUM_DIGITS  hex value to display; nibble i drives digit i.
- load  input  1  single-cycle strobe; captures value into the pending register.
- lz_suppress  input  1  1 = blank leading zero digits; sampled together with value on load.
- nibble  output  4  hex digit to the decoder input.
- anode_n  output  NUM_DIGITS  active-low digit enables; at most one bit is low.
- digit_idx  output  $clog2(NUM_DIGITS)  index of the current or next digit.
- frame_done  output  1  one-cycle pulse when digit_idx wraps to 0.
- pending  output  1  high while a loaded value awaits frame-boundary transfer.

Behaviour:
- Reset (rst=1 at a clk edge): active and pending registers are 0; lz flags are 0; pending=0. State=GUARD, guard counter 0, prescaler 0. digit_idx=0, nibble=0, anode_n all ones, frame_done=0.
- Two-state FSM, SHOW and GUARD:
  - GUARD: anode_n all ones for exactly BLANK_GUARD cycles. nibble already shows the digit at digit_idx, so the decoder settles before the anode enables.
  - GUARD -> SHOW: at the end of the guard interval.
  - SHOW: anode_n[digit_idx]=0 for exactly REFRESH_DIV cycles, unless that digit is blanked, in which case anode_n stays all ones.
  - SHOW -> GUARD: at the end of the show interval. In the same edge, digit_idx advances (NUM_DIGITS-1 wraps to 0) and nibble updates to the new digit.
- One full digit slot is REFRESH_DIV+BLANK_GUARD cycles. One frame is NUM_DIGITS slots.
- Outputs are registered: nibble, anode_n, digit_idx and frame_done all change only on clk edges.
- Load handshake:
  - load=1 copies value and lz_suppress into the pending register and sets pending=1.
  - A load while pending=1 overwrites the pending register (last write wins).
- Frame boundary (the edge where digit_idx wraps to 0):
  - If pending=1, pending contents move to the active register and pending clears.
  - frame_done pulses high for one cycle in that same edge.
  - Display is tear-free: a frame never mixes old and new digits.
- Simultaneous load and frame boundary:
  - The transfer uses the old pending contents.
  - The new value lands in pending and pending stays 1.
  - With pending=0, the transfer does not occur and the new value waits for the next boundary.
- First frame after reset: digits 0..NUM_DIGITS-1 display 0 (zeros are not suppressed because the lz flag resets to 0).
- Leading-zero suppression (only when the active lz flag is 1):
  - Digit i, for i>=1, is blanked if every active nibble from index NUM_DIGITS-1 down to i is 0.
  - Digit 0 is never blanked.
  - The blank decision is combinational on the active register and is registered into anode_n.
- Blanked digits keep full slot timing, so the brightness of the other digits does not depend on how many are blanked.
- rst asserted mid-frame returns the block to the reset state on that edge. Any pending load is discarded.
- Counter widths are $clog2 of the respective parameter. No counter overflows past its terminal count.

Decomposition:
- Shared display package holds:
  - the state enum {SHOW, GUARD};
  - NIBBLE_W=4;
  - a function lz_mask(value, lz) returning a NUM_DIGITS-bit blank mask.
- One sub-module: scan_timer, the prescaler plus guard counter. It emits show_end and guard_end pulses.
- The FSM, value registers and anode logic stay in display_scanner.
- The existing hex-to-segment decoder is instantiated by the top level, not inside this block.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_GUARD=1):
1. Reset, then run 2 frames with no load -> anode_n follows 1111 (guard), 1110×4, 1111, 1101×4, 1111, 1011×4, 1111, 0111×4. nibble=0 throughout; frame_done pulses every 20 cycles.
2. load value=16'h1A2F with lz_suppress=0 mid-frame -> pending=1 until the next wrap. The following frame shows nibbles F,2,A,1 on digits 0..3. pending clears in the same cycle frame_done pulses.
3. load value=16'h003C with lz_suppress=1 -> digits 3 and 2 keep anode_n high through their whole slot; digits 1 and 0 show 3 and C; slot timing stays 5 cycles each. Then value=16'h0000 with lz_suppress=1 -> only digit 0 lights, showing 0.
4. Two loads in one frame (16'h1111, then 16'h2222) -> the next frame shows 2222 only; 1111 is never displayed.
5. load 16'h5555 in the exact cycle of the wrap, with pending holding 16'h7777 -> that frame shows 7777, pending stays 1, and the following frame shows 5555.
6. Assert rst for 1 cycle while digit 2 is in SHOW -> the next cycle has anode_n=1111, digit_idx=0, pending=0, nibble=0. The timing sequence of scenario 1 restarts.
